// File: rtl/prod_acc_4bit.sv
// Sums N_ACC 8-bit products per result; result presented the cycle after the last beat, held until out_ready.
// Input stalls (in_ready=0) while a result is pending. Define PROD_ACC_SATURATE_EN to clamp instead of wrap.
module prod_acc_4bit #(
  parameter int N_ACC = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       prod,
  output logic             in_ready,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int CW = $clog2(N_ACC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic [ACC_W:0]   sum;
  logic             in_fire;
  logic             out_fire;
  logic             last_beat;

  // Handshake-facing outputs are decoded from state only.
  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign acc_out   = acc;
  assign ovf       = ovf_q;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_beat = (cnt == CW'(N_ACC - 1));
  assign sum       = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};

`ifdef PROD_ACC_SATURATE_EN
  // Once any carry has occurred the sum stays pinned at full scale.
  assign acc_nxt = (ovf_q || sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: begin
        if (in_fire) begin
          state_nxt = last_beat ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr || out_fire) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (in_fire) begin
      acc   <= acc_nxt;
      cnt   <= cnt + CW'(1);
      ovf_q <= ovf_q | sum[ACC_W];
    end
  end

endmodule

// File: tb/tb_prod_acc_4bit.sv
// Three instances: N_ACC=4 (default), N_ACC=20 (overflow), N_ACC=1 (single-beat); checked against an arithmetic model.
module tb_prod_acc_4bit;

  localparam int MAXV = 4095;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic [7:0]  prod      [3];
  logic        in_ready  [3];
  logic        clr       [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [11:0] acc_out   [3];
  logic        ovf       [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prod_acc_4bit #(.N_ACC(4), .ACC_W(12)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .prod(prod[0]), .in_ready(in_ready[0]),
    .clr(clr[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .acc_out(acc_out[0]), .ovf(ovf[0]));

  prod_acc_4bit #(.N_ACC(20), .ACC_W(12)) u_big (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .prod(prod[1]), .in_ready(in_ready[1]),
    .clr(clr[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .acc_out(acc_out[1]), .ovf(ovf[1]));

  prod_acc_4bit #(.N_ACC(1), .ACC_W(12)) u_one (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .prod(prod[2]), .in_ready(in_ready[2]),
    .clr(clr[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .acc_out(acc_out[2]), .ovf(ovf[2]));

  // Final sum of a set of products whose plain integer total is given.
  function automatic int model_sum(input int total);
`ifdef PROD_ACC_SATURATE_EN
    return (total > MAXV) ? MAXV : total;
`else
    return total % (MAXV + 1);
`endif
  endfunction

  task automatic send(input int d, input logic [7:0] p, input int gap);
    in_valid[d] = 1'b1;
    prod[d]     = p;
    @(negedge clk);
    in_valid[d] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input int d);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]); end
      checks++; if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]); end
      checks++; if (acc_out[d] !== 12'd0) begin errors++; $display("FAIL reset_acc_out[%0d]: got %0d want 0", d, acc_out[d]); end
      checks++; if (ovf[d] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d]: got %b want 0", d, ovf[d]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) send(0, 8'd225, 0);
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b want 0", out_valid[0]); end
    send(0, 8'd225, 0);
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL b2b_out_valid: got %b want 1", out_valid[0]); end
    checks++; if (acc_out[0] !== 12'd900) begin errors++; $display("FAIL b2b_acc_out: got %0d want 900", acc_out[0]); end
    checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", ovf[0]); end
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b want 0", in_ready[0]); end
    // Offered beats while the result is pending must be ignored.
    in_valid[0] = 1'b1; prod[0] = 8'd5;
    repeat (2) @(negedge clk);
    in_valid[0] = 1'b0;
    checks++; if (acc_out[0] !== 12'd900) begin errors++; $display("FAIL b2b_no_overlap: got %0d want 900", acc_out[0]); end
    drain(0);
    checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || acc_out[0] !== 12'd0) begin
      errors++; $display("FAIL b2b_return_idle: got valid=%b ready=%b acc=%0d want 0/1/0", out_valid[0], in_ready[0], acc_out[0]);
    end
  endtask

  task automatic test_gaps_stall();
    int pv [4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      send(0, pv[i][7:0], (i < 3) ? 2 : 0);
      if (i < 3) begin
        checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
          errors++; $display("FAIL gap_stall_state: got valid=%b ready=%b want 0/1", out_valid[0], in_ready[0]);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid[0] !== 1'b1 || acc_out[0] !== 12'd100) begin
        errors++; $display("FAIL gap_hold: got valid=%b acc=%0d want 1/100", out_valid[0], acc_out[0]);
      end
      @(negedge clk);
    end
    drain(0);
    checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL gap_idle: got valid=%b ready=%b want 0/1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_random(input int d, input int n, input int ntx);
    for (int t = 0; t < ntx; t++) begin
      int total = 0;
      int lo = (t % 2 == 1) ? 150 : 0;
      int expv;
      bit expo;
      int hold;
      for (int i = 0; i < n; i++) begin
        int p = $urandom_range(255, lo);
        total += p;
        send(d, p[7:0], (i == n - 1) ? 0 : $urandom_range(2, 0));
      end
      expv = model_sum(total);
      expo = (total > MAXV);
      checks++; if (out_valid[d] !== 1'b1) begin errors++; $display("FAIL rand%0d_latency: got %b want 1", d, out_valid[d]); end
      checks++; if (acc_out[d] !== expv[11:0]) begin errors++; $display("FAIL rand%0d_acc: got %0d want %0d", d, acc_out[d], expv); end
      checks++; if (ovf[d] !== expo) begin errors++; $display("FAIL rand%0d_ovf: got %b want %b", d, ovf[d], expo); end
      hold = $urandom_range(3, 0);
      repeat (hold) @(negedge clk);
      checks++; if (out_valid[d] !== 1'b1 || acc_out[d] !== expv[11:0]) begin
        errors++; $display("FAIL rand%0d_hold: got valid=%b acc=%0d want 1/%0d", d, out_valid[d], acc_out[d], expv);
      end
      drain(d);
      checks++; if (out_valid[d] !== 1'b0 || ovf[d] !== 1'b0) begin
        errors++; $display("FAIL rand%0d_release: got valid=%b ovf=%b want 0/0", d, out_valid[d], ovf[d]);
      end
    end
  endtask

  task automatic test_saturate();
    int expv;
`ifdef PROD_ACC_SATURATE_EN
    expv = 4095;
`else
    expv = 404;
`endif
    for (int i = 0; i < 20; i++) send(1, 8'd225, 0);
    checks++; if (out_valid[1] !== 1'b1 || acc_out[1] !== expv[11:0]) begin
      errors++; $display("FAIL ovf20_acc: got valid=%b acc=%0d want 1/%0d", out_valid[1], acc_out[1], expv);
    end
    checks++; if (ovf[1] !== 1'b1) begin errors++; $display("FAIL ovf20_flag: got %b want 1", ovf[1]); end
    // clr wins over a simultaneous output handshake and clears the sticky flag.
    clr[1] = 1'b1; out_ready[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0; out_ready[1] = 1'b0;
    checks++; if (ovf[1] !== 1'b0 || out_valid[1] !== 1'b0 || acc_out[1] !== 12'd0) begin
      errors++; $display("FAIL ovf20_clr: got ovf=%b valid=%b acc=%0d want 0/0/0", ovf[1], out_valid[1], acc_out[1]);
    end
  endtask

  task automatic test_clr();
    send(0, 8'd50, 0);
    send(0, 8'd50, 0);
    in_valid[0] = 1'b1; prod[0] = 8'd50; clr[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0; clr[0] = 1'b0;
    checks++; if (acc_out[0] !== 12'd0 || in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL clr_abort: got acc=%0d ready=%b valid=%b want 0/1/0", acc_out[0], in_ready[0], out_valid[0]);
    end
    for (int i = 0; i < 4; i++) send(0, 8'd1, 0);
    checks++; if (out_valid[0] !== 1'b1 || acc_out[0] !== 12'd4 || ovf[0] !== 1'b0) begin
      errors++; $display("FAIL clr_restart: got valid=%b acc=%0d ovf=%b want 1/4/0", out_valid[0], acc_out[0], ovf[0]);
    end
    drain(0);
  endtask

  task automatic test_reset_in_done();
    for (int i = 0; i < 4; i++) send(0, 8'd9, 0);
    checks++; if (out_valid[0] !== 1'b1 || acc_out[0] !== 12'd36) begin
      errors++; $display("FAIL rstdone_pre: got valid=%b acc=%0d want 1/36", out_valid[0], acc_out[0]);
    end
    rst = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b0 || acc_out[0] !== 12'd0 || in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL rstdone_clear: got valid=%b acc=%0d ready=%b want 0/0/1", out_valid[0], acc_out[0], in_ready[0]);
    end
    for (int i = 0; i < 4; i++) send(0, 8'd7, 0);
    checks++; if (out_valid[0] !== 1'b1 || acc_out[0] !== 12'd28) begin
      errors++; $display("FAIL rstdone_after: got valid=%b acc=%0d want 1/28", out_valid[0], acc_out[0]);
    end
    drain(0);
  endtask

  task automatic test_single();
    int p = 255;
    prod[2] = 8'd255; in_valid[2] = 1'b1; out_ready[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0 || acc_out[2] !== p[11:0] || ovf[2] !== 1'b0) begin
        errors++; $display("FAIL single_present: got valid=%b ready=%b acc=%0d ovf=%b want 1/0/%0d/0",
                           out_valid[2], in_ready[2], acc_out[2], ovf[2], p);
      end
      p = $urandom_range(255, 0);
      prod[2] = p[7:0];
      @(negedge clk);
      checks++; if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
        errors++; $display("FAIL single_accept: got valid=%b ready=%b want 0/1", out_valid[2], in_ready[2]);
      end
    end
    in_valid[2] = 1'b0; out_ready[2] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; prod[d] = 8'd0; clr[d] = 1'b0; out_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_gaps_stall();
    test_random(0, 4, 8);
    test_random(1, 20, 6);
    test_saturate();
    test_clr();
    test_reset_in_done();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prod_acc_4bit.md
PROD_ACC_4BIT -- requirements
Module: prod_acc_4bit

Interface
REQ-001 SHALL have parameter N_ACC, default 4, meaning products summed per result (legal range 1..255).
REQ-002 SHALL have parameter ACC_W, default 12, meaning accumulator and result width in bits (legal range 8..32).
REQ-003 SHALL have port clk  input  1  rising-edge clock; sole clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream asserts that prod holds a valid 8-bit product.
REQ-006 SHALL have port prod  input  8  unsigned product from the 4x4 multiplier stage.
REQ-007 SHALL have port in_ready  output  1  block can accept prod this cycle.
REQ-008 SHALL have port clr  input  1  abort the current sum and return to IDLE.
REQ-009 SHALL have port out_valid  output  1  acc_out holds a completed sum.
REQ-010 SHALL have port out_ready  input  1  downstream accepts acc_out this cycle.
REQ-011 SHALL have port acc_out  output  ACC_W  completed sum of N_ACC products.
REQ-012 SHALL have port ovf  output  1  sum exceeded 2^ACC_W-1.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-014 IDLE SHALL assert in_ready=1, with accumulator=0 and count=0.
REQ-015 Input handshake SHALL be in_valid&in_ready at the clk edge; the block SHALL add prod, zero-extended to ACC_W+1 bits, to the accumulator and increment the count.
REQ-016 On the first accepted beat, IDLE SHALL go to ACCUM, or directly to DONE when N_ACC=1.
REQ-017 ACCUM SHALL assert in_ready=1 and SHALL go to DONE on the clk edge that accepts beat number N_ACC.
REQ-018 out_valid SHALL rise on the cycle after the last beat is accepted, giving 1-cycle latency.
REQ-019 DONE SHALL assert in_ready=0 and out_valid=1, holding acc_out and ovf stable until out_valid&out_ready.
REQ-020 Output handshake SHALL return the FSM to IDLE on the next edge, clearing the accumulator and count.
REQ-021 DONE SHALL NOT accept input while holding a result, so there is no result overlap.
REQ-022 in_valid=0 in ACCUM SHALL stall with no state change; gaps SHALL be allowed between beats.
REQ-023 clr=1 in any state SHALL force IDLE with accumulator=0, count=0, ovf=0 and out_valid=0 on the next edge.
REQ-024 clr SHALL take priority over a simultaneous input or output handshake; the beat is dropped and the result is discarded.
REQ-025 A carry out of bit ACC_W-1 during an add SHALL set ovf, which is sticky until clr, reset or the output handshake.
REQ-026 The counter SHALL be $clog2(N_ACC+1) bits wide, compare exactly to N_ACC and never wrap.
REQ-027 out_valid and in_ready SHALL be registered or decoded from state only; there SHALL be no combinational path from in_valid or out_ready to any output.

Reset
REQ-028 rst=1 at a clk edge SHALL force IDLE, accumulator=0, count=0, acc_out=0, ovf=0, out_valid=0 and in_ready=1 after the edge.
REQ-029 rst SHALL override clr and both handshakes; reset mid-ACCUM or in DONE SHALL discard the partial sum or result.

Configuration
REQ-030 Macro PROD_ACC_SATURATE_EN, when defined, SHALL clamp the accumulator at 2^ACC_W-1 once it overflows and hold that value for the rest of the sum, with ovf=1.
REQ-031 Without PROD_ACC_SATURATE_EN, the sum SHALL wrap modulo 2^ACC_W and ovf SHALL still report overflow.
REQ-032 Both builds SHALL have identical ports and handshake timing.

Verification
REQ-033 Default parameters, after rst, prod=225 for 4 back-to-back beats -> out_valid on cycle 5, acc_out=900, ovf=0, in_ready=0 while out_valid=1.
REQ-034 Default parameters, prod=10,20,30,40 with in_valid low 2 cycles between beats, out_ready held 0 for 3 cycles -> acc_out=100 held stable; IDLE on the edge after out_ready=1.
REQ-035 N_ACC=20, ACC_W=12, prod=225 x20 -> with PROD_ACC_SATURATE_EN acc_out=4095, ovf=1; without it acc_out=404, ovf=1.
REQ-036 Default parameters, 2 beats of 50 then clr=1 together with in_valid=1, then 4 beats of 1 -> acc_out=4, ovf=0.
REQ-037 rst=1 asserted in DONE with out_ready=1 on the same edge -> out_valid=0 and acc_out=0; the next 4 beats of 7 -> acc_out=28.
REQ-038 N_ACC=1, prod=255 -> out_valid on the next cycle with acc_out=255; back-to-back results alternate accept/present, with in_ready low one cycle per result.
